// File: rtl/csr_regfile_if.sv
// CSR commit-side bus between the system-instruction decoder/commit stage
// and the machine-mode CSR register file.
// Handshake: i_valid qualifies every other i_* field for one cycle.
// There is no back-pressure: the register file always accepts a committing
// instruction. o_csrsdata and o_illegal answer in the same cycle.
// o_redirect_valid is a one-cycle registered pulse with no ready.
interface csr_regfile_if #(
    parameter int CPU_WIDTH = 32,
    parameter int CSR_ADDRW = 12
);
    logic                 i_valid;
    logic [CSR_ADDRW-1:0] i_csrsid;
    logic                 i_csrsren;
    logic [CSR_ADDRW-1:0] i_csrdid;
    logic                 i_csrdwen;
    logic [1:0]           i_excsropt;
    logic                 i_excsrsrc;
    logic [CPU_WIDTH-1:0] i_rs1data;
    logic [CPU_WIDTH-1:0] i_imm;
    logic [CPU_WIDTH-1:0] i_pc;
    logic                 i_ecall;
    logic                 i_mret;
    logic [CPU_WIDTH-1:0] o_csrsdata;
    logic                 o_illegal;
    logic                 o_redirect_valid;
    logic [CPU_WIDTH-1:0] o_redirect_pc;

    modport master (
        output i_valid, i_csrsid, i_csrsren, i_csrdid, i_csrdwen,
               i_excsropt, i_excsrsrc, i_rs1data, i_imm, i_pc,
               i_ecall, i_mret,
        input  o_csrsdata, o_illegal, o_redirect_valid, o_redirect_pc
    );

    modport slave (
        input  i_valid, i_csrsid, i_csrsren, i_csrdid, i_csrdwen,
               i_excsropt, i_excsrsrc, i_rs1data, i_imm, i_pc,
               i_ecall, i_mret,
        output o_csrsdata, o_illegal, o_redirect_valid, o_redirect_pc
    );
endinterface

// File: rtl/csr_regfile.sv
// Machine-mode CSR register file with ecall/mret trap sequencing.
// Read-modify-write is atomic within the commit cycle; old value is
// returned combinationally. Trap redirects are registered one cycle later.
module csr_regfile #(
    parameter int CPU_WIDTH = 32,
    parameter int CSR_ADDRW = 12
) (
    input  logic          i_clk,
    input  logic          i_rst,
    csr_regfile_if.slave  bus
);
    localparam logic [CSR_ADDRW-1:0] A_MSTATUS  = CSR_ADDRW'(12'h300);
    localparam logic [CSR_ADDRW-1:0] A_MTVEC    = CSR_ADDRW'(12'h305);
    localparam logic [CSR_ADDRW-1:0] A_MSCRATCH = CSR_ADDRW'(12'h340);
    localparam logic [CSR_ADDRW-1:0] A_MEPC     = CSR_ADDRW'(12'h341);
    localparam logic [CSR_ADDRW-1:0] A_MCAUSE   = CSR_ADDRW'(12'h342);
    localparam logic [CSR_ADDRW-1:0] A_MCYCLE   = CSR_ADDRW'(12'hB00);
    localparam logic [CSR_ADDRW-1:0] A_MCYCLEH  = CSR_ADDRW'(12'hB80);

    // mstatus only keeps MIE/MPIE; MPP is a constant 11 on read.
    logic                   r_mie;
    logic                   r_mpie;
    logic [CPU_WIDTH-1:0]   r_mtvec;
    logic [CPU_WIDTH-1:0]   r_mscratch;
    logic [CPU_WIDTH-1:0]   r_mepc;
    logic [CPU_WIDTH-1:0]   r_mcause;
    logic [2*CPU_WIDTH-1:0] r_cycle;
    logic                   r_redirect_valid;
    logic [CPU_WIDTH-1:0]   r_redirect_pc;

    logic [CPU_WIDTH-1:0]   w_mstatus;
    logic [CPU_WIDTH-1:0]   w_rd_val;
    logic                   w_rd_impl;
    logic [CPU_WIDTH-1:0]   w_old;
    logic                   w_wr_impl;
    logic [CPU_WIDTH-1:0]   w_src;
    logic [CPU_WIDTH-1:0]   w_wdata;
    logic                   w_illegal;
    logic                   w_ecall;
    logic                   w_mret;
    logic                   w_wr_en;

    // Assemble the architectural mstatus view from the stored bits.
    always_comb begin
        w_mstatus        = '0;
        w_mstatus[12:11] = 2'b11;
        w_mstatus[7]     = r_mpie;
        w_mstatus[3]     = r_mie;
    end

    // Read port decode: value and implemented flag for i_csrsid.
    always_comb begin
        w_rd_val  = '0;
        w_rd_impl = 1'b1;
        case (bus.i_csrsid)
            A_MSTATUS:  w_rd_val = w_mstatus;
            A_MTVEC:    w_rd_val = r_mtvec;
            A_MSCRATCH: w_rd_val = r_mscratch;
            A_MEPC:     w_rd_val = r_mepc;
            A_MCAUSE:   w_rd_val = r_mcause;
            A_MCYCLE:   w_rd_val = r_cycle[CPU_WIDTH-1:0];
            A_MCYCLEH:  w_rd_val = r_cycle[2*CPU_WIDTH-1:CPU_WIDTH];
            default:    w_rd_impl = 1'b0;
        endcase
    end

    // Write port decode: old value of i_csrdid feeds the modify step.
    always_comb begin
        w_old     = '0;
        w_wr_impl = 1'b1;
        case (bus.i_csrdid)
            A_MSTATUS:  w_old = w_mstatus;
            A_MTVEC:    w_old = r_mtvec;
            A_MSCRATCH: w_old = r_mscratch;
            A_MEPC:     w_old = r_mepc;
            A_MCAUSE:   w_old = r_mcause;
            A_MCYCLE:   w_old = r_cycle[CPU_WIDTH-1:0];
            A_MCYCLEH:  w_old = r_cycle[2*CPU_WIDTH-1:CPU_WIDTH];
            default:    w_wr_impl = 1'b0;
        endcase
    end

    // Modify step and commit qualification; traps override CSR writes.
    always_comb begin
        w_src = bus.i_excsrsrc ? bus.i_imm : bus.i_rs1data;
        case (bus.i_excsropt)
            2'b01:   w_wdata = w_src;
            2'b10:   w_wdata = w_old | w_src;
            2'b11:   w_wdata = w_old & ~w_src;
            default: w_wdata = w_old;
        endcase
        w_illegal = bus.i_valid &&
                    ((bus.i_csrsren && !w_rd_impl) || (bus.i_csrdwen && !w_wr_impl));
        w_ecall   = bus.i_valid && bus.i_ecall;
        w_mret    = bus.i_valid && bus.i_mret && !bus.i_ecall;
        w_wr_en   = bus.i_valid && bus.i_csrdwen && (bus.i_excsropt != 2'b00) &&
                    w_wr_impl && !w_illegal && !w_ecall && !w_mret;
    end

    assign bus.o_csrsdata       = (bus.i_valid && bus.i_csrsren && !w_illegal) ? w_rd_val : '0;
    assign bus.o_illegal        = w_illegal;
    assign bus.o_redirect_valid = r_redirect_valid;
    assign bus.o_redirect_pc    = r_redirect_pc;

    // mstatus interrupt-enable stack: trap entry/exit beat software writes.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mie  <= 1'b0;
            r_mpie <= 1'b0;
        end else if (w_ecall) begin
            r_mpie <= r_mie;
            r_mie  <= 1'b0;
        end else if (w_mret) begin
            r_mie  <= r_mpie;
            r_mpie <= 1'b1;
        end else if (w_wr_en && bus.i_csrdid == A_MSTATUS) begin
            r_mie  <= w_wdata[3];
            r_mpie <= w_wdata[7];
        end
    end

    // Plain storage CSRs; ecall captures the trapping PC and cause.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mtvec    <= '0;
            r_mscratch <= '0;
            r_mepc     <= '0;
            r_mcause   <= '0;
        end else if (w_ecall) begin
            r_mepc   <= {bus.i_pc[CPU_WIDTH-1:2], 2'b00};
            r_mcause <= CPU_WIDTH'(11);
        end else if (w_wr_en) begin
            case (bus.i_csrdid)
                A_MTVEC:    r_mtvec    <= {w_wdata[CPU_WIDTH-1:2], 2'b00};
                A_MSCRATCH: r_mscratch <= w_wdata;
                A_MEPC:     r_mepc     <= {w_wdata[CPU_WIDTH-1:2], 2'b00};
                A_MCAUSE:   r_mcause   <= w_wdata;
                default:    ;
            endcase
        end
    end

    // Free-running cycle counter; a write to either half takes that half.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cycle <= '0;
        end else if (w_wr_en && bus.i_csrdid == A_MCYCLE) begin
            r_cycle[CPU_WIDTH-1:0] <= w_wdata;
        end else if (w_wr_en && bus.i_csrdid == A_MCYCLEH) begin
            r_cycle[2*CPU_WIDTH-1:CPU_WIDTH] <= w_wdata;
            r_cycle[CPU_WIDTH-1:0]           <= r_cycle[CPU_WIDTH-1:0] + 1'b1;
        end else begin
            r_cycle <= r_cycle + 1'b1;
        end
    end

    // Registered redirect: pulse for one cycle, target held afterwards.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
        end else begin
            r_redirect_valid <= w_ecall || w_mret;
            if (w_ecall)
                r_redirect_pc <= r_mtvec;
            else if (w_mret)
                r_redirect_pc <= r_mepc;
        end
    end
endmodule

// File: tb/tb_csr_regfile.sv
// Directed bench for csr_regfile: inputs change at the falling edge,
// combinational outputs are sampled 1 ns later, state commits on the
// following rising edge.
module tb_csr_regfile;
    localparam int W  = 32;
    localparam int AW = 12;

    logic i_clk;
    logic i_rst;
    int   n_checks;
    int   n_errors;

    csr_regfile_if #(.CPU_WIDTH(W), .CSR_ADDRW(AW)) bus ();

    csr_regfile #(.CPU_WIDTH(W), .CSR_ADDRW(AW)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus.slave)
    );

    // Clock: 10 ns period.
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Present one committing instruction for a full cycle.
    task automatic drive(input logic [AW-1:0] sid, input logic sren,
                         input logic [AW-1:0] did, input logic dwen,
                         input logic [1:0] opt, input logic src,
                         input logic [W-1:0] rs1, input logic [W-1:0] imm,
                         input logic ecall, input logic mret, input logic [W-1:0] pc);
        @(negedge i_clk);
        bus.i_valid    = 1'b1;
        bus.i_csrsid   = sid;
        bus.i_csrsren  = sren;
        bus.i_csrdid   = did;
        bus.i_csrdwen  = dwen;
        bus.i_excsropt = opt;
        bus.i_excsrsrc = src;
        bus.i_rs1data  = rs1;
        bus.i_imm      = imm;
        bus.i_ecall    = ecall;
        bus.i_mret     = mret;
        bus.i_pc       = pc;
        #1;
    endtask

    // csr read-modify-write: reads and writes the same address.
    task automatic csr_op(input logic [AW-1:0] a, input logic [1:0] opt,
                          input logic src, input logic [W-1:0] val);
        drive(a, 1'b1, a, 1'b1, opt, src, val, val, 1'b0, 1'b0, '0);
    endtask

    task automatic rd(input logic [AW-1:0] a);
        drive(a, 1'b1, '0, 1'b0, 2'b00, 1'b0, '0, '0, 1'b0, 1'b0, '0);
    endtask

    task automatic rd_chk(input string tag, input logic [AW-1:0] a, input logic [W-1:0] exp);
        rd(a);
        check(tag, bus.o_csrsdata, exp);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        bus.i_valid = 1'b0; bus.i_csrsid = '0; bus.i_csrsren = 1'b0;
        bus.i_csrdid = '0; bus.i_csrdwen = 1'b0; bus.i_excsropt = 2'b00;
        bus.i_excsrsrc = 1'b0; bus.i_rs1data = '0; bus.i_imm = '0;
        bus.i_pc = '0; bus.i_ecall = 1'b0; bus.i_mret = 1'b0;
        i_rst = 1'b1;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;

        // Reset state
        check("rst_redir_v", W'(bus.o_redirect_valid), 32'h0);
        check("rst_redir_pc", bus.o_redirect_pc, 32'h0);
        rd_chk("rst_mstatus", 12'h300, 32'h0000_1800);
        check("rst_illegal", W'(bus.o_illegal), 32'h0);
        rd_chk("rst_mtvec", 12'h305, 32'h0);
        rd_chk("rst_mepc", 12'h341, 32'h0);
        rd_chk("rst_mcause", 12'h342, 32'h0);
        rd_chk("rst_mscratch", 12'h340, 32'h0);

        // Chained read-modify-write on mscratch
        csr_op(12'h340, 2'b01, 1'b0, 32'hDEAD_BEEF);
        check("rw_old", bus.o_csrsdata, 32'h0);
        csr_op(12'h340, 2'b10, 1'b1, 32'h0000_0010);
        check("rs_old", bus.o_csrsdata, 32'hDEAD_BEEF);
        csr_op(12'h340, 2'b11, 1'b1, 32'h0000_000F);
        check("rc_old", bus.o_csrsdata, 32'hDEAD_BEFF);
        rd_chk("rc_new", 12'h340, 32'hDEAD_BEF0);

        // Write masks
        csr_op(12'h305, 2'b01, 1'b0, 32'h8000_0103);
        rd_chk("mtvec_mask", 12'h305, 32'h8000_0100);
        csr_op(12'h341, 2'b01, 1'b0, 32'hFFFF_FFFF);
        rd_chk("mepc_mask", 12'h341, 32'hFFFF_FFFC);
        csr_op(12'h300, 2'b01, 1'b0, 32'hFFFF_FFFF);
        rd_chk("mstatus_mask", 12'h300, 32'h0000_1888);
        csr_op(12'h300, 2'b01, 1'b0, 32'h0000_0000);
        rd_chk("mstatus_clr", 12'h300, 32'h0000_1800);

        // ecall then mret
        csr_op(12'h300, 2'b10, 1'b1, 32'h0000_0008);
        check("set_mie_old", bus.o_csrsdata, 32'h0000_1800);
        drive('0, 1'b0, '0, 1'b0, 2'b00, 1'b0, '0, '0, 1'b1, 1'b0, 32'h8000_0046);
        check("ecall_no_early", W'(bus.o_redirect_valid), 32'h0);
        rd_chk("ecall_mepc", 12'h341, 32'h8000_0044);
        check("ecall_redir_v", W'(bus.o_redirect_valid), 32'h1);
        check("ecall_redir_pc", bus.o_redirect_pc, 32'h8000_0100);
        rd_chk("ecall_mcause", 12'h342, 32'h0000_000B);
        check("ecall_pulse_end", W'(bus.o_redirect_valid), 32'h0);
        check("ecall_pc_held", bus.o_redirect_pc, 32'h8000_0100);
        rd_chk("ecall_mstatus", 12'h300, 32'h0000_1880);
        drive('0, 1'b0, '0, 1'b0, 2'b00, 1'b0, '0, '0, 1'b0, 1'b1, '0);
        rd_chk("mret_mstatus", 12'h300, 32'h0000_1888);
        check("mret_redir_v", W'(bus.o_redirect_valid), 32'h1);
        check("mret_redir_pc", bus.o_redirect_pc, 32'h8000_0044);

        // Illegal access
        drive(12'h7C0, 1'b1, 12'h7C0, 1'b1, 2'b01, 1'b0, 32'h1234_5678, '0, 1'b0, 1'b0, '0);
        check("ill_flag", W'(bus.o_illegal), 32'h1);
        check("ill_data", bus.o_csrsdata, 32'h0);
        drive(12'h340, 1'b1, 12'h7C0, 1'b1, 2'b01, 1'b0, 32'h1234_5678, '0, 1'b0, 1'b0, '0);
        check("ill_wr_flag", W'(bus.o_illegal), 32'h1);
        check("ill_wr_data", bus.o_csrsdata, 32'h0);
        rd_chk("ill_nochange", 12'h340, 32'hDEAD_BEF0);

        // ecall + mret + csrrw together: ecall only
        drive(12'h340, 1'b1, 12'h340, 1'b1, 2'b01, 1'b0, 32'h0000_1234, '0, 1'b1, 1'b1, 32'h0000_0102);
        rd_chk("sim_mscratch", 12'h340, 32'hDEAD_BEF0);
        check("sim_redir_v", W'(bus.o_redirect_valid), 32'h1);
        check("sim_redir_pc", bus.o_redirect_pc, 32'h8000_0100);
        rd_chk("sim_mepc", 12'h341, 32'h0000_0100);
        rd_chk("sim_mstatus", 12'h300, 32'h0000_1880);

        // Counter carry: low half across three cycles
        csr_op(12'hB00, 2'b01, 1'b0, 32'hFFFF_FFFE);
        csr_op(12'hB80, 2'b01, 1'b0, 32'h0000_0000);
        rd_chk("cyc_lo0", 12'hB00, 32'hFFFF_FFFF);
        rd_chk("cyc_lo1", 12'hB00, 32'h0000_0000);
        rd_chk("cyc_lo2", 12'hB00, 32'h0000_0001);
        // Same sequence, high half
        csr_op(12'hB00, 2'b01, 1'b0, 32'hFFFF_FFFE);
        csr_op(12'hB80, 2'b01, 1'b0, 32'h0000_0000);
        rd_chk("cyc_hi0", 12'hB80, 32'h0000_0000);
        rd_chk("cyc_hi1", 12'hB80, 32'h0000_0001);
        rd_chk("cyc_hi2", 12'hB80, 32'h0000_0001);

        // Asynchronous reset mid-count, with a redirect pending
        drive('0, 1'b0, '0, 1'b0, 2'b00, 1'b0, '0, '0, 1'b1, 1'b0, 32'h0000_0200);
        @(posedge i_clk);
        #2;
        i_rst = 1'b1;
        #1;
        check("arst_redir_v", W'(bus.o_redirect_valid), 32'h0);
        check("arst_redir_pc", bus.o_redirect_pc, 32'h0);
        rd_chk("arst_cyc_lo", 12'hB00, 32'h0);
        rd_chk("arst_cyc_hi", 12'hB80, 32'h0);
        rd_chk("arst_mepc", 12'h341, 32'h0);
        @(negedge i_clk);
        i_rst = 1'b0;
        rd_chk("post_rst_cyc", 12'hB00, 32'h0000_0001);

        bus.i_valid = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
